fifo_rd_fwft: RTL

// - Read-domain output stage of the async FIFO; sits directly downstream of the read-pointer/empty logic.
// - Turns the FIFO's registered `empty` flag and synchronous-RAM read port into a first-word-fall-through

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_rd_skid2.sv | 70 +++++++
 rtl/fifo_rd_fwft.sv | 60 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: width defaults, output-buffer occupancy encoding,
// and the skid-buffer control bundle.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PTR_WIDTH_DEF  = 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } fwft_st_e;

  typedef struct packed {
    logic push;   // RAM word lands this edge
    logic pop;    // consumer takes slot0 this edge
  } skid_ctl_t;

  // Words that will be held or in flight after this edge, before any new request.
  function automatic logic [2:0] occ_next(input logic [1:0] cnt, input logic infl,
                                          input logic pop);
    return {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry output buffer (slot0 = head, slot1 = next) with simultaneous push/pop.
// The state encoding doubles as the buffered-word count.
module fifo_rd_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  skid_ctl_t             ctl,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            cnt,
  output logic                  vld
);

  fwft_st_e              st_q, st_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      st_q    <= S_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      st_q    <= st_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (st_q)
      S_EMPTY: begin
        if (ctl.push) begin
          slot0_d = din;
          st_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (ctl.push && ctl.pop) begin
          slot0_d = din;
        end else if (ctl.push) begin
          slot1_d = din;
          st_d    = S_TWO;
        end else if (ctl.pop) begin
          st_d    = S_EMPTY;
        end
      end
      S_TWO: begin
        // Push without pop cannot happen here: the requester never overcommits.
        if (ctl.pop) begin
          slot0_d = slot1_q;
          if (ctl.push) slot1_d = din;
          else          st_d    = S_ONE;
        end
      end
      default: st_d = S_EMPTY;
    endcase
  end

  assign dout = slot0_q;
  assign cnt  = st_q;
  assign vld  = (st_q != S_EMPTY);

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-side first-word-fall-through stage: issues RAM reads and streams words out.
// Optional FWFT_LEVEL_EN exposes the buffered-word count on o_level.
module fifo_rd_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FWFT_LEVEL_EN
  ,
  output logic [1:0]            o_level
`endif
);

  logic       inflight_q, inflight_d;
  logic       pop;
  logic [1:0] cnt;
  logic [2:0] occ;
  skid_ctl_t  ctl;

  assign pop = m_valid & m_ready;
  assign occ = occ_next(cnt, inflight_q, pop);

  // Gated by reset so no read is requested while the pointer block is also held.
  always_comb begin
    r_en       = rrst_n & ~empty & (occ < 3'd2);
    inflight_d = r_en;
    ctl.push   = inflight_q;
    ctl.pop    = pop;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  fifo_rd_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .ctl    (ctl),
    .din    (rdata),
    .dout   (m_data),
    .cnt    (cnt),
    .vld    (m_valid)
  );

`ifdef FWFT_LEVEL_EN
  assign o_level = cnt;
`endif

endmodule
